// File: rtl/lsu_ctrl.sv
// Load/store control in front of the word-addressed, byte-masked data_mem.
// Aligns byte/half/word accesses, splits word-crossing ones in two, and extends load data.
module lsu_ctrl #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  localparam int MEM_BYTES     = MEM_SIZE_IN_KB * 1024,
  localparam int ADDRW         = $clog2(MEM_BYTES / 4)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_store_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DW-1:0]    rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             dm_we_o,
  output logic             dm_cs_o,
  output logic [3:0]       dm_mask_o,
  output logic [ADDRW-1:0] dm_addr_o,
  output logic [DW-1:0]    dm_wdata_o,
  input  logic [DW-1:0]    dm_rdata_i
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_r;
  logic             store_r;
  logic             split_r;
  logic [2:0]       f3_r;
  logic [1:0]       off_r;
  logic [ADDRW-1:0] waddr_r;
  logic [3:0]       mask_hi_r;
  logic [DW-1:0]    wdata_hi_r;
  logic [DW-1:0]    lo_r;

  logic [2:0]       size_s;
  logic [7:0]       mask_base_s;
  logic             f3_ok_s;
  logic [32:0]      end_s;
  logic             err_s;
  logic             split_s;
  logic [7:0]       lane_s;
  logic [2*DW-1:0]  wide_s;

  // Shift the {hi, lo} word pair down to the access offset, then size and extend.
  function automatic logic [DW-1:0] load_extract(input logic [2*DW-1:0] pair,
                                                 input logic [1:0] off,
                                                 input logic [2:0] f3);
    logic [2*DW-1:0] sh;
    sh = pair >> {off, 3'b000};
    case (f3)
      3'd0:    load_extract = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_extract = {{16{sh[15]}}, sh[15:0]};
      3'd2:    load_extract = sh[31:0];
      3'd4:    load_extract = {24'd0, sh[7:0]};
      3'd5:    load_extract = {16'd0, sh[15:0]};
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Decode the incoming request: size, legality, range, split and lane alignment.
  always_comb begin
    size_s      = 3'd4;
    mask_base_s = 8'h0F;
    f3_ok_s     = 1'b0;
    case (req_funct3_i[1:0])
      2'd0:    begin size_s = 3'd1; mask_base_s = 8'h01; end
      2'd1:    begin size_s = 3'd2; mask_base_s = 8'h03; end
      default: begin size_s = 3'd4; mask_base_s = 8'h0F; end
    endcase
    if (req_store_i) begin
      f3_ok_s = (req_funct3_i <= 3'd2);
    end else begin
      case (req_funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok_s = 1'b1;
        default:                      f3_ok_s = 1'b0;
      endcase
    end
    // 33-bit sum so an address wrapping past 0xFFFFFFFF still reads as out of range
    end_s   = {1'b0, req_addr_i} + {30'd0, size_s} - 33'd1;
    err_s   = !f3_ok_s || (end_s >= MEM_LIMIT);
    split_s = ({1'b0, req_addr_i[1:0]} + size_s) > 3'd4;
    lane_s  = mask_base_s << req_addr_i[1:0];
    wide_s  = {{DW{1'b0}}, req_wdata_i} << {req_addr_i[1:0], 3'b000};
  end

  // Access sequencer with registered request, memory and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      store_r     <= 1'b0;
      split_r     <= 1'b0;
      f3_r        <= 3'd0;
      off_r       <= 2'd0;
      waddr_r     <= '0;
      mask_hi_r   <= 4'd0;
      wdata_hi_r  <= '0;
      lo_r        <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      dm_we_o     <= 1'b0;
      dm_cs_o     <= 1'b0;
      dm_mask_o   <= 4'd0;
      dm_addr_o   <= '0;
      dm_wdata_o  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_ready_o && req_valid_i) begin
            req_ready_o <= 1'b0;
            store_r     <= req_store_i;
            split_r     <= split_s;
            f3_r        <= req_funct3_i;
            off_r       <= req_addr_i[1:0];
            waddr_r     <= req_addr_i[ADDRW+1:2];
            mask_hi_r   <= lane_s[7:4];
            wdata_hi_r  <= wide_s[2*DW-1:DW];
            if (err_s) begin
              state_r     <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state_r    <= ACC0;
              dm_cs_o    <= 1'b1;
              dm_we_o    <= req_store_i;
              dm_addr_o  <= req_addr_i[ADDRW+1:2];
              dm_mask_o  <= lane_s[3:0];
              dm_wdata_o <= wide_s[DW-1:0];
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ACC0: begin
          lo_r <= dm_rdata_i;
          if (split_r) begin
            state_r    <= ACC1;
            dm_cs_o    <= 1'b1;
            dm_we_o    <= store_r;
            dm_addr_o  <= waddr_r + {{(ADDRW-1){1'b0}}, 1'b1};
            dm_mask_o  <= mask_hi_r;
            dm_wdata_o <= wdata_hi_r;
          end else begin
            state_r     <= RESP;
            dm_cs_o     <= 1'b0;
            dm_we_o     <= 1'b0;
            dm_mask_o   <= 4'd0;
            dm_addr_o   <= '0;
            dm_wdata_o  <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= store_r ? '0 : load_extract({{DW{1'b0}}, dm_rdata_i}, off_r, f3_r);
          end
        end
        ACC1: begin
          state_r     <= RESP;
          dm_cs_o     <= 1'b0;
          dm_we_o     <= 1'b0;
          dm_mask_o   <= 4'd0;
          dm_addr_o   <= '0;
          dm_wdata_o  <= '0;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= store_r ? '0 : load_extract({dm_rdata_i, lo_r}, off_r, f3_r);
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_r     <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_o <= 1'b0;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          dm_cs_o     <= 1'b0;
          dm_we_o     <= 1'b0;
          dm_mask_o   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array reference model, word memory model,
// directed corner cases followed by randomized load/store traffic.
module tb_lsu_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int ADDRW     = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_store_i;
  logic [2:0]       req_funct3_i;
  logic [31:0]      req_addr_i;
  logic [31:0]      req_wdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_err_o;
  logic             dm_we_o;
  logic             dm_cs_o;
  logic [3:0]       dm_mask_o;
  logic [ADDRW-1:0] dm_addr_o;
  logic [31:0]      dm_wdata_o;
  logic [31:0]      dm_rdata_i;

  lsu_ctrl #(.DW(32), .MEM_SIZE_IN_KB(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .dm_we_o(dm_we_o), .dm_cs_o(dm_cs_o), .dm_mask_o(dm_mask_o),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // data_mem stand-in: combinational read, byte-masked write on the rising edge
  logic [31:0] dmem [256];
  assign dm_rdata_i = dmem[dm_addr_o];
  always @(posedge clk_i) begin
    if (dm_cs_o && dm_we_o) begin
      for (int b = 0; b < 4; b++)
        if (dm_mask_o[b]) dmem[dm_addr_o][8*b +: 8] <= dm_wdata_o[8*b +: 8];
    end
  end

  logic [7:0] ref_mem [MEM_BYTES];

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [ADDRW-1:0] acc_addr [2];
  logic [3:0]       acc_mask [2];
  logic [31:0]      acc_wd   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-granular memory, RV32I size/extension rules
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output bit err,
                       output int lat, output int ncs);
    int size;
    bit legal;
    logic [63:0] a64;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a64   = {32'd0, addr};
    err   = !legal || (a64 + 64'(size) > 64'(MEM_BYTES));
    rd    = 32'd0;
    if (err) begin
      lat = 1; ncs = 0;
    end else begin
      ncs = ((int'(addr[1:0]) + size) > 4) ? 2 : 1;
      lat = ncs + 1;
      v = 32'd0;
      for (int i = 0; i < size; i++) begin
        if (st) ref_mem[int'(addr[9:0]) + i] = wd[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[int'(addr[9:0]) + i];
      end
      if (!st) begin
        case (f3)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  // Monitor: every presented response is compared with the head of the queue
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end else begin
        chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_q[0].err});
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err_o}, 32'd0);
    chk({tag, "_dm_cs"},     {31'd0, dm_cs_o}, 32'd0);
    chk({tag, "_dm_we"},     {31'd0, dm_we_o}, 32'd0);
    chk({tag, "_dm_mask"},   {28'd0, dm_mask_o}, 32'd0);
    chk({tag, "_dm_addr"},   {24'd0, dm_addr_o}, 32'd0);
    chk({tag, "_dm_wdata"},  dm_wdata_o, 32'd0);
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        input bit use_want, input logic [31:0] want);
    logic [31:0] mrd;
    bit merr, got;
    int mlat, mncs, lat, ncs;
    model(st, f3, addr, wd, mrd, merr, mlat, mncs);
    exp_q.push_back('{rdata: (use_want ? want : mrd), err: merr});
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd; rsp_ready_i = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (req_ready_o) got = 1'b1;
    end
    chk("req_ready_wait", {31'd0, got}, 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0; ncs = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      lat++;
      if (dm_cs_o) begin
        if (ncs < 2) begin
          acc_addr[ncs] = dm_addr_o; acc_mask[ncs] = dm_mask_o; acc_wd[ncs] = dm_wdata_o;
        end
        ncs++;
      end
      if (rsp_valid_o) got = 1'b1;
    end
    chk("rsp_latency", lat, mlat);
    chk("cs_cycles", ncs, mncs);
    if (got && hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        chk("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
      end
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    chk("post_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, w;
    logic [2:0]  f;
    bit          s;
    for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; rsp_ready_i = 1'b1;

    #12;
    chk_all_zero("reset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

    do_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 1'b0, 32'd0);
    chk("sw_acc_addr", {24'd0, acc_addr[0]}, 32'd4);
    chk("sw_acc_mask", {28'd0, acc_mask[0]}, 32'hF);
    chk("sw_acc_wdata", acc_wd[0], 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h010, 32'd0, 0, 1'b1, 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'h020, 32'h80FF7F01, 0, 1'b0, 32'd0);
    do_req(1'b0, 3'd0, 32'h023, 32'd0, 0, 1'b1, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h023, 32'd0, 0, 1'b1, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h022, 32'd0, 0, 1'b1, 32'hFFFF80FF);
    do_req(1'b0, 3'd5, 32'h020, 32'd0, 0, 1'b1, 32'h00007F01);

    do_req(1'b1, 3'd2, 32'h005, 32'h11223344, 0, 1'b0, 32'd0);
    chk("split_acc0_addr", {24'd0, acc_addr[0]}, 32'd1);
    chk("split_acc0_mask", {28'd0, acc_mask[0]}, 32'hE);
    chk("split_acc0_wdata", acc_wd[0], 32'h22334400);
    chk("split_acc1_addr", {24'd0, acc_addr[1]}, 32'd2);
    chk("split_acc1_mask", {28'd0, acc_mask[1]}, 32'h1);
    chk("split_acc1_wdata", acc_wd[1], 32'h00000011);
    do_req(1'b0, 3'd2, 32'h005, 32'd0, 0, 1'b1, 32'h11223344);

    do_req(1'b0, 3'd2, 32'h3FE, 32'd0, 0, 1'b0, 32'd0);
    do_req(1'b0, 3'd1, 32'h3FF, 32'd0, 0, 1'b0, 32'd0);
    do_req(1'b0, 3'd0, 32'h3FF, 32'd0, 0, 1'b0, 32'd0);
    do_req(1'b0, 3'd3, 32'h040, 32'd0, 0, 1'b0, 32'd0);
    do_req(1'b1, 3'd2, 32'hFFFFFFFE, 32'h12345678, 0, 1'b0, 32'd0);

    do_req(1'b0, 3'd2, 32'h010, 32'd0, 5, 1'b1, 32'hDEADBEEF);

    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                      : (s ? 3'($urandom_range(0, 2))
                                           : 3'(($urandom_range(0, 1) << 2) | $urandom_range(0, 2)));
      if (f == 3'd6) f = 3'd4;
      a = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, MEM_BYTES - 1));
      w = 32'($urandom);
      do_req(s, f, a, w, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, 1'b0, 32'd0);
    end

    // Reset in the middle of a split store: no response may follow
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'd2;
    req_addr_i = 32'h0F6; req_wdata_i = 32'hCAFEF00D; rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_acc0_cs", {31'd0, dm_cs_o}, 32'd1);
    @(negedge clk_i);
    chk("mid_rst_acc1_cs", {31'd0, dm_cs_o}, 32'd1);
    chk("mid_rst_acc1_addr", {24'd0, dm_addr_o}, 32'h3E);
    chk("mid_rst_acc1_mask", {28'd0, dm_mask_o}, 32'h3);
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_mid_rst", {31'd0, req_ready_o}, 32'd1);
    do_req(1'b0, 3'd2, 32'h010, 32'd0, 0, 1'b0, 32'd0);

    repeat (3) @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
